// File: rtl/sa_cache.sv
// Set-associative write-back, write-allocate cache with a single outstanding miss.
// Refill and writeback go over one request port; refill data comes back as one line-wide beat.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | ready for a new request; captures addr/we/wdata on accept
//   ST_LOOKUP  | tag compare over all ways of the set, pick victim on miss
//   ST_WB_REQ  | dirty victim line offered to the lower level
//   ST_RF_REQ  | refill read of the requested line offered to the lower level
//   ST_RF_WAIT | waiting for the refill beat; installs line and merges write
//   ST_RESPOND | response held on valid_out until ready_in
module sa_cache #(
  parameter int A = 3,
  parameter int B = 64,
  parameter int C = 1536,
  parameter int W = 64,
  parameter int D = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cs_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             we_in,
  input  logic [W-1:0]     in_addr,
  input  logic [D-1:0]     wdata_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             hit_out,
  output logic [D-1:0]     data_out,
  output logic             mem_req_valid_out,
  input  logic             mem_req_ready_in,
  output logic             mem_req_we_out,
  output logic [W-1:0]     mem_req_addr_out,
  output logic [8*B-1:0]   mem_req_data_out,
  input  logic             mem_resp_valid_in,
  input  logic [8*B-1:0]   mem_resp_data_in
);

  localparam int S    = C / (A * B);
  localparam int OFF  = $clog2(B);
  localparam int IDX  = $clog2(S);
  localparam int TW   = W - OFF - IDX;
  localparam int LINE = 8 * B;
  localparam int LB   = $clog2(LINE);
  localparam int RW   = (A > 1) ? $clog2(A) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_WB_REQ, ST_RF_REQ, ST_RF_WAIT, ST_RESPOND
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]    addr_q;
  logic            we_q;
  logic [D-1:0]    wdata_q;
  logic [RW-1:0]   victim_q;
  logic            resp_hit_q;
  logic [D-1:0]    resp_data_q;

  logic [A-1:0]    valid_q [S];
  logic [A-1:0]    dirty_q [S];
  logic [RW-1:0]   rr_q    [S];
  logic [TW-1:0]   tag_q   [S][A];
  logic [LINE-1:0] data_q  [S][A];

  logic            accept;
  logic [IDX-1:0]  idx;
  logic [TW-1:0]   tag;
  logic [LB-1:0]   bit_lo;
  logic            hit;
  logic [RW-1:0]   hit_way;
  logic [LINE-1:0] hit_line;
  logic [RW-1:0]   rr_cur;
  logic            victim_dirty;
  logic [RW-1:0]   rr_next;
  logic [LINE-1:0] fill_line;
  logic            fill;

  assign accept = cs_in & valid_in;
  assign idx    = addr_q[OFF +: IDX];
  assign tag    = addr_q[W-1 -: TW];
  // bit position of the addressed D-bit word inside the line; sub-word byte bits drop out
  assign bit_lo = {addr_q[OFF-1:0], 3'b000} & ~LB'(D - 1);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = 0; i < A; i++) begin
      if (valid_q[idx][i] && (tag_q[idx][i] == tag)) begin
        hit     = 1'b1;
        hit_way = RW'(i);
      end
    end
  end

  assign hit_line     = data_q[idx][hit_way];
  assign rr_cur       = rr_q[idx];
  assign victim_dirty = valid_q[idx][rr_cur] & dirty_q[idx][rr_cur];
  assign rr_next      = (rr_cur == RW'(A - 1)) ? '0 : rr_cur + 1'b1;
  assign fill         = (state_q == ST_RF_WAIT) && mem_resp_valid_in;

  always_comb begin
    fill_line = mem_resp_data_in;
    if (we_q) fill_line[bit_lo +: D] = wdata_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)               state_d = ST_RESPOND;
        else if (victim_dirty) state_d = ST_WB_REQ;
        else                   state_d = ST_RF_REQ;
      end
      ST_WB_REQ:  if (mem_req_ready_in)  state_d = ST_RF_REQ;
      ST_RF_REQ:  if (mem_req_ready_in)  state_d = ST_RF_WAIT;
      ST_RF_WAIT: if (mem_resp_valid_in) state_d = ST_RESPOND;
      ST_RESPOND: if (ready_in)          state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_out         = 1'b0;
    valid_out         = 1'b0;
    hit_out           = 1'b0;
    data_out          = '0;
    mem_req_valid_out = 1'b0;
    mem_req_we_out    = 1'b0;
    mem_req_addr_out  = '0;
    mem_req_data_out  = '0;
    case (state_q)
      ST_IDLE: ready_out = 1'b1;
      ST_WB_REQ: begin
        mem_req_valid_out = 1'b1;
        mem_req_we_out    = 1'b1;
        mem_req_addr_out  = {tag_q[idx][victim_q], idx, {OFF{1'b0}}};
        mem_req_data_out  = data_q[idx][victim_q];
      end
      ST_RF_REQ: begin
        mem_req_valid_out = 1'b1;
        mem_req_addr_out  = {addr_q[W-1:OFF], {OFF{1'b0}}};
      end
      ST_RESPOND: begin
        valid_out = 1'b1;
        hit_out   = resp_hit_q;
        data_out  = resp_data_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      victim_q    <= '0;
      resp_hit_q  <= 1'b0;
      resp_data_q <= '0;
      for (int s = 0; s < S; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= in_addr;
            we_q    <= we_in;
            wdata_q <= wdata_in;
          end
        end
        ST_LOOKUP: begin
          victim_q <= rr_cur;
          if (hit) begin
            resp_hit_q  <= 1'b1;
            resp_data_q <= we_q ? wdata_q : hit_line[bit_lo +: D];
            if (we_q) dirty_q[idx][hit_way] <= 1'b1;
          end
        end
        ST_RF_WAIT: begin
          if (mem_resp_valid_in) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= we_q;
            rr_q[idx]              <= rr_next;
            resp_hit_q             <= 1'b0;
            resp_data_q            <= we_q ? wdata_q : mem_resp_data_in[bit_lo +: D];
          end
        end
        default: ;
      endcase
    end
  end

  // tag/data storage carries no reset; validity lives in valid_q
  always_ff @(posedge clk_in) begin
    if ((state_q == ST_LOOKUP) && hit && we_q) begin
      data_q[idx][hit_way][bit_lo +: D] <= wdata_q;
    end else if (fill) begin
      tag_q[idx][victim_q]  <= tag;
      data_q[idx][victim_q] <= fill_line;
    end
  end

endmodule
